muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/mdu_abs.sv | 13 +
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and
// controller states, plus small decode helpers used by the top level.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } state_e;

   function automatic logic op_signed(input op_e o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

   function automatic logic op_is_div(input op_e o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_abs.sv
// Conditional two's-complement negation, used both to take operand magnitudes
// and to restore the sign of results.
module mdu_abs #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring-subtract
// step per cycle on magnitudes, then a single sign-fix cycle.
//
// state | meaning
// IDLE  | waiting for start; direct hi/lo writes accepted here
// CALC  | WIDTH iterations of shift-add (mult) or restoring subtract (div)
// FIX   | sign correction of product/quotient/remainder, then commit hi/lo
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic             divz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_e             state;
   op_e                op_in;
   logic               sgn_in;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   mq;
   logic [WIDTH-1:0]   dvs;
   logic [WIDTH-1:0]   a_raw;
   logic               is_div_q;
   logic               b_zero;
   logic               neg_res;
   logic               neg_rem;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_in;
   logic               sub_ge;
   logic [WIDTH-1:0]   sub_diff;

   assign op_in  = op_e'(op);
   assign sgn_in = op_signed(op_in);
   assign busy   = (state != IDLE);

   mdu_abs #(.WIDTH(WIDTH)) u_abs_a (
      .value(a), .negate(sgn_in & a[WIDTH-1]), .result(mag_a)
   );
   mdu_abs #(.WIDTH(WIDTH)) u_abs_b (
      .value(b), .negate(sgn_in & b[WIDTH-1]), .result(mag_b)
   );
   mdu_abs #(.WIDTH(2*WIDTH)) u_fix_prod (
      .value({acc, mq}), .negate(neg_res), .result(prod_fix)
   );
   mdu_abs #(.WIDTH(WIDTH)) u_fix_quo (
      .value(mq), .negate(neg_res), .result(quo_fix)
   );
   mdu_abs #(.WIDTH(WIDTH)) u_fix_rem (
      .value(acc), .negate(neg_rem), .result(rem_fix)
   );

   // Multiply: {acc,mq} shifts right, multiplier bits consumed from mq[0].
   // Divide: {acc,mq} shifts left, quotient bits enter at mq[0].
   assign add_sum  = mq[0] ? ({1'b0, acc} + {1'b0, dvs}) : {1'b0, acc};
   assign sub_in   = {acc, mq[WIDTH-1]};
   assign sub_ge   = (sub_in >= {1'b0, dvs});
   assign sub_diff = sub_in[WIDTH-1:0] - dvs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         mq       <= '0;
         dvs      <= '0;
         a_raw    <= '0;
         is_div_q <= 1'b0;
         b_zero   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         done     <= 1'b0;
         divz     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_raw    <= a;
                  mq       <= mag_a;
                  dvs      <= mag_b;
                  acc      <= '0;
                  is_div_q <= op_is_div(op_in);
                  b_zero   <= (b == '0);
                  neg_res  <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem  <= sgn_in & a[WIDTH-1];
                  cnt      <= CW'(WIDTH - 1);
                  state    <= CALC;
               end else begin
                  if (hi_we) hi <= wd;
                  if (lo_we) lo <= wd;
               end
            end
            CALC: begin
               if (is_div_q) begin
                  acc <= sub_ge ? sub_diff : sub_in[WIDTH-1:0];
                  mq  <= {mq[WIDTH-2:0], sub_ge};
               end else begin
                  acc <= add_sum[WIDTH:1];
                  mq  <= {add_sum[0], mq[WIDTH-1:1]};
               end
               if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            FIX: begin
               if (is_div_q) begin
                  if (b_zero) begin
                     hi <= a_raw;
                     lo <= '1;
                  end else begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end
               end else begin
                  {hi, lo} <= prod_fix;
               end
               divz  <= is_div_q & b_zero;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit (WIDTH=32) with an
// arithmetic reference model of MULT/MULTU/DIV/DIVU.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         hi_we;
   logic         lo_we;
   logic [W-1:0] wd;
   logic         busy;
   logic         done;
   logic         divz;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_hi;
   logic [W-1:0] exp_lo;
   logic         exp_dz;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
      .busy(busy), .done(done), .divz(divz), .hi(hi), .lo(lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: plain 64-bit arithmetic; SV division truncates toward zero
   // and % takes the dividend's sign, matching the required semantics.
   task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
      longint          sx, sy, p;
      longint unsigned ux, uy, up;
      sx = $signed(x);
      sy = $signed(y);
      ux = {32'b0, x};
      uy = {32'b0, y};
      dz = 1'b0;
      case (o)
         2'b00: begin p = sx * sy; {h, l} = p; end
         2'b01: begin up = ux * uy; {h, l} = up; end
         default: begin
            if (y == '0) begin
               h  = x;
               l  = '1;
               dz = 1'b1;
            end else if (o == 2'b10) begin
               p = sx / sy; l = p[31:0];
               p = sx % sy; h = p[31:0];
            end else begin
               up = ux / uy; l = up[31:0];
               up = ux % uy; h = up[31:0];
            end
         end
      endcase
   endtask

   // Called at #1 after an edge with the DUT idle; returns at #1 into the done cycle.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit junk, input bit pulse, input bit we_start);
      logic [W-1:0] e_hi, e_lo;
      logic         e_dz;
      int           cyc, busy_bad;
      bit           got;
      model(o, x, y, e_hi, e_lo, e_dz);
      op = o; a = x; b = y; start = 1'b1;
      if (we_start) begin
         hi_we = 1'b1; lo_we = 1'b1; wd = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      check("hold_hi", {32'b0, hi}, {32'b0, exp_hi});
      check("hold_lo", {32'b0, lo}, {32'b0, exp_lo});
      cyc = 1; busy_bad = 0; got = 0;
      while (cyc < 80 && !got) begin
         if (done === 1'b1) begin
            got = 1;
         end else begin
            if (busy !== 1'b1) busy_bad++;
            if (junk) begin
               a = $urandom; b = $urandom; op = 2'($urandom); wd = $urandom;
               hi_we = 1'($urandom); lo_we = 1'($urandom);
            end
            start = pulse && (cyc == 5);
            @(posedge clk); #1;
            cyc++;
         end
      end
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      check("done_cycle", 64'(cyc), 64'(W + 2));
      check("busy_cycles", 64'(busy_bad), 64'd0);
      check("busy_at_done", {63'b0, busy}, 64'd0);
      check("hi", {32'b0, hi}, {32'b0, e_hi});
      check("lo", {32'b0, lo}, {32'b0, e_lo});
      check("divz", {63'b0, divz}, {63'b0, e_dz});
      exp_hi = e_hi; exp_lo = e_lo; exp_dz = e_dz;
   endtask

   initial begin
      logic [1:0]   ro;
      logic [W-1:0] rx, ry;
      int           bad;

      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wd = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_done", {63'b0, done}, 64'd0);
      check("rst_divz", {63'b0, divz}, 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed vectors
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
      run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 0, 0, 0);
      run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 0, 0, 0);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
      run_op(2'b11, 32'h00000007, 32'h00000000, 0, 0, 0);
      run_op(2'b01, 32'h00000002, 32'h00000003, 0, 0, 0);
      run_op(2'b10, 32'h80000005, 32'h00000000, 0, 0, 0);
      run_op(2'b00, 32'h80000000, 32'h80000000, 0, 0, 0);

      // Direct HI/LO writes in IDLE, then write-with-start must not write
      @(posedge clk); #1;
      hi_we = 1'b1; wd = 32'h12345678;
      @(posedge clk); #1;
      hi_we = 1'b0;
      check("mthi", {32'b0, hi}, 64'h12345678);
      check("mthi_lo_kept", {32'b0, lo}, {32'b0, exp_lo});
      exp_hi = 32'h12345678;
      lo_we = 1'b1; wd = 32'h9ABCDEF0;
      @(posedge clk); #1;
      lo_we = 1'b0;
      check("mtlo", {32'b0, lo}, 64'h9ABCDEF0);
      exp_lo = 32'h9ABCDEF0;
      run_op(2'b01, 32'd3, 32'd5, 0, 0, 1);

      // Randomized: back-to-back starts, junk inputs and writes while busy,
      // ignored start pulses, occasional idle gaps
      for (int i = 0; i < 36; i++) begin
         ro = 2'($urandom);
         rx = $urandom;
         ry = $urandom;
         case ($urandom_range(0, 7))
            0: ry = '0;
            1: ry = 32'hFFFFFFFF;
            2: rx = 32'h80000000;
            3: ry = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(ro, rx, ry, 1, (i % 3) == 0, (i % 4) == 1);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      // Reset in the middle of a divide after an ignored start pulse
      run_op(2'b11, 32'h00000055, 32'h00000000, 0, 0, 0);
      op = 2'b11; a = 32'h0000FFFF; b = 32'h00000003; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_pulse", {63'b0, busy}, 64'd1);
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      check("abort_busy", {63'b0, busy}, 64'd0);
      check("abort_done", {63'b0, done}, 64'd0);
      check("abort_divz", {63'b0, divz}, 64'd0);
      check("abort_hilo", {hi, lo}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      bad = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("no_done_after_abort", 64'(bad), 64'd0);
      exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
      run_op(2'b01, 32'd4, 32'd4, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
